// File: rtl/shift_unit.sv
// Universal shift register with parallel load, four shift modes and a multi-position
// shift command (start/amount) reported through busy/done. State updates on the falling clock edge.
module shift_unit #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned AMT_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             start_i,
    input  logic [1:0]       mode_i,
    input  logic [AMT_W-1:0] amount_i,
    input  logic             ser_in_i,
    output logic [WIDTH-1:0] q_o,
    output logic             ser_out_o,
    output logic             busy_o,
    output logic             done_o
);

    typedef enum logic {StIdle, StShift} state_e;

    localparam logic [1:0] ModeLsr = 2'b00;
    localparam logic [1:0] ModeAsr = 2'b01;
    localparam logic [1:0] ModeLsl = 2'b10;
    localparam logic [1:0] ModeRor = 2'b11;

    state_e             state_q, state_d;
    logic [1:0]         mode_q, mode_d;
    logic [AMT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic               ser_q, ser_d;
    logic               done_q, done_d;

    logic [WIDTH-1:0]   shifted;
    logic               shift_bit;

    always_ff @(negedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            mode_q  <= 2'b00;
            cnt_q   <= '0;
            shreg_q <= '0;
            ser_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            ser_q   <= ser_d;
            done_q  <= done_d;
        end
    end

    // One single-bit shift of the current contents under the latched mode.
    always_comb begin
        shifted   = shreg_q;
        shift_bit = shreg_q[0];
        case (mode_q)
            ModeLsr: shifted = {ser_in_i, shreg_q[WIDTH-1:1]};
            ModeAsr: shifted = {shreg_q[WIDTH-1], shreg_q[WIDTH-1:1]};
            ModeLsl: begin
                shifted   = {shreg_q[WIDTH-2:0], ser_in_i};
                shift_bit = shreg_q[WIDTH-1];
            end
            ModeRor: shifted = {shreg_q[0], shreg_q[WIDTH-1:1]};
            default: shifted = shreg_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        ser_d   = ser_q;
        done_d  = 1'b0;
        case (state_q)
            StIdle: begin
                if (load_i) begin
                    shreg_d = din_i;
                    ser_d   = 1'b0;
                end else if (start_i) begin
                    if (amount_i == '0) begin
                        done_d = 1'b1;
                    end else begin
                        mode_d  = mode_i;
                        cnt_d   = amount_i;
                        state_d = StShift;
                    end
                end
            end
            StShift: begin
                shreg_d = shifted;
                ser_d   = shift_bit;
                cnt_d   = cnt_q - AMT_W'(1);
                if (cnt_q == AMT_W'(1)) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        q_o       = shreg_q;
        ser_out_o = ser_q;
        busy_o    = (state_q == StShift);
        done_o    = done_q;
    end

endmodule

// File: tb/tb_shift_unit.sv
// Directed bench for shift_unit: a behavioural model checked every rising edge,
// plus hand-computed literal results for each command.
module tb_shift_unit;

    logic        clk = 1'b1;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] din = '0;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [4:0]  amount = '0;
    logic        ser_in = 1'b0;
    logic [15:0] q;
    logic        ser_out, busy, done;

    int checks = 0;
    int errors = 0;

    shift_unit #(.WIDTH(16), .AMT_W(5)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .load_i    (load),
        .din_i     (din),
        .start_i   (start),
        .mode_i    (mode),
        .amount_i  (amount),
        .ser_in_i  (ser_in),
        .q_o       (q),
        .ser_out_o (ser_out),
        .busy_o    (busy),
        .done_o    (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: remaining shift count; register value updated with plain arithmetic.
    logic [15:0] m_q = '0;
    logic        m_ser = 1'b0;
    logic        m_done = 1'b0;
    int          m_left = 0;
    logic [1:0]  m_mode = 2'b00;

    always @(negedge clk or posedge rst) begin
        if (rst) begin
            m_q <= '0; m_ser <= 1'b0; m_done <= 1'b0; m_left <= 0; m_mode <= 2'b00;
        end else if (m_left == 0) begin
            m_done <= 1'b0;
            if (load) begin
                m_q <= din; m_ser <= 1'b0;
            end else if (start) begin
                if (amount == 0) m_done <= 1'b1;
                else begin
                    m_left <= amount; m_mode <= mode;
                end
            end
        end else begin
            case (m_mode)
                2'd0: m_q <= (m_q >> 1) + (ser_in ? 16'h8000 : 16'h0000);
                2'd1: m_q <= 16'($signed(m_q) >>> 1);
                2'd2: m_q <= (m_q << 1) + {15'd0, ser_in};
                default: m_q <= (m_q >> 1) | (m_q << 15);
            endcase
            m_ser  <= (m_mode == 2'd2) ? m_q[15] : m_q[0];
            m_left <= m_left - 1;
            m_done <= (m_left == 1);
        end
    end

    always @(posedge clk) begin
        check("q", 32'(q), 32'(m_q));
        check("ser_out", 32'(ser_out), 32'(m_ser));
        check("busy", 32'(busy), 32'(m_left != 0));
        check("done", 32'(done), 32'(m_done));
    end

    task automatic do_load(input logic [15:0] d);
        @(posedge clk); load = 1'b1; din = d;
        @(posedge clk); load = 1'b0;
        check("load_q", 32'(q), 32'(d));
    endtask

    // Issue one command and count busy cycles and done pulses over a bounded window.
    task automatic run_cmd(input logic [1:0] m, input logic [4:0] amt, input logic si,
                           input bit disturb, input string tag);
        int nb, nd;
        @(posedge clk); start = 1'b1; mode = m; amount = amt; ser_in = si;
        @(posedge clk); start = 1'b0;
        nb = 0; nd = 0;
        for (int i = 0; i < int'(amt) + 4; i++) begin
            if (busy) nb++;
            if (done) nd++;
            if (disturb && i == 1) begin
                load = 1'b1; start = 1'b1; din = 16'hFFFF; mode = ~m; amount = 5'd3;
            end
            if (disturb && i == 2) begin
                load = 1'b0; start = 1'b0;
            end
            @(posedge clk);
        end
        check({tag, "_busy_cycles"}, 32'(nb), 32'(amt));
        check({tag, "_done_pulses"}, 32'(nd), 32'd1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        check("reset_q", 32'(q), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        rst = 1'b0;

        do_load(16'hA5F0);
        run_cmd(2'b00, 5'd4, 1'b0, 1'b0, "lsr");
        check("lsr_q", 32'(q), 32'h0A5F);
        check("lsr_ser", 32'(ser_out), 32'h0);

        do_load(16'h8001);
        run_cmd(2'b01, 5'd3, 1'b1, 1'b0, "asr");
        check("asr_q", 32'(q), 32'hF000);
        check("asr_ser", 32'(ser_out), 32'h0);

        do_load(16'h8001);
        run_cmd(2'b11, 5'd1, 1'b0, 1'b0, "ror");
        check("ror_q", 32'(q), 32'hC000);
        check("ror_ser", 32'(ser_out), 32'h1);

        do_load(16'h0001);
        run_cmd(2'b10, 5'd16, 1'b1, 1'b0, "lsl");
        check("lsl_q", 32'(q), 32'hFFFF);
        check("lsl_ser", 32'(ser_out), 32'h1);

        do_load(16'h8001);
        run_cmd(2'b11, 5'd20, 1'b0, 1'b0, "ror20");
        check("ror20_q", 32'(q), 32'h1800);
        check("ror20_ser", 32'(ser_out), 32'h0);

        // amount = 0: done only, contents untouched
        run_cmd(2'b00, 5'd0, 1'b1, 1'b0, "zero");
        check("zero_q", 32'(q), 32'h1800);

        // load/start while busy are ignored
        do_load(16'h00F0);
        run_cmd(2'b00, 5'd4, 1'b1, 1'b1, "busy_ign");
        check("busy_ign_q", 32'(q), 32'hF00F);
        check("busy_ign_ser", 32'(ser_out), 32'h0);

        // Abort mid-command with an asynchronous reset
        @(posedge clk); start = 1'b1; mode = 2'b00; amount = 5'd10; ser_in = 1'b1;
        @(posedge clk); start = 1'b0;
        repeat (3) @(posedge clk);
        check("abort_busy_pre", 32'(busy), 32'h1);
        #2 rst = 1'b1;
        #1;
        check("abort_q", 32'(q), 32'h0);
        check("abort_ser", 32'(ser_out), 32'h0);
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_done", 32'(done), 32'h0);
        @(posedge clk); rst = 1'b0;
        check("abort_no_done", 32'(done), 32'h0);

        // Load wins over start on the same edge
        @(posedge clk); load = 1'b1; start = 1'b1; din = 16'h1234; amount = 5'd5;
        @(posedge clk); load = 1'b0; start = 1'b0;
        check("prio_q", 32'(q), 32'h1234);
        check("prio_busy", 32'(busy), 32'h0);
        @(posedge clk);
        check("prio_busy2", 32'(busy), 32'h0);
        check("prio_done", 32'(done), 32'h0);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
